// File: rtl/branch_predictor_table_pkg.sv
// Shared types for the branch predictor family: FSM state, legacy 2-bit
// counter encoding and the weakly-not-taken initial value helper.
package branch_predictor_table_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  // Legacy fixed 2-bit encoding, kept for CTR_W=2 users.
  typedef enum logic [1:0] {
    BP_SNT = 2'd0,
    BP_WNT = 2'd1,
    BP_WT  = 2'd2,
    BP_ST  = 2'd3
  } branch_pred_t;

  function automatic int unsigned ctr_wnt(input int unsigned ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// Combinational next-value for an up/down saturating counter of CTR_W bits.
module sat_counter_next #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_next
);

  always_comb begin
    o_next = i_ctr;
    if (i_inc) begin
      if (i_ctr != '1) o_next = i_ctr + 1'b1;
    end else if (i_ctr != '0) begin
      o_next = i_ctr - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_table.sv
// PC/gshare-indexed saturating-counter direction predictor with self-initialisation.
// Optional branch target buffer enabled by defining BRANCH_PRED_BTB_EN.
module branch_predictor_table
  import branch_predictor_table_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned GHR_W   = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  output logic              ready,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              lookup_taken,
  output logic              lookup_hit,
  output logic [WORD_W-1:0] lookup_target,
  input  logic              upd_valid,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target
);

  localparam int unsigned      IDX_W    = $clog2(ENTRIES);
  localparam int unsigned      GHR_RW   = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [IDX_W-1:0] GHR_MASK = (GHR_W > 0) ? '1 : '0;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_wnt(CTR_W));

  bp_state_t         r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [GHR_RW-1:0] r_ghr;
  logic              r_ready;
  logic [CTR_W-1:0]  r_ctr [ENTRIES];

  logic [IDX_W-1:0]  w_ghr_idx;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [CTR_W-1:0]  w_ctr_next;
  logic              w_restart;
  logic              w_upd_en;

  // With GHR_W=0 a 1-bit history register still exists but is masked out of the index.
  assign w_ghr_idx = IDX_W'(r_ghr) & GHR_MASK;
  assign w_lk_idx  = lookup_pc[IDX_W+1:2] ^ w_ghr_idx;
  assign w_upd_idx = upd_pc[IDX_W+1:2] ^ w_ghr_idx;
  assign w_restart = RST | flush;
  assign w_upd_en  = upd_valid & r_ready & ~w_restart;

  sat_counter_next #(.CTR_W(CTR_W)) u_sat (
    .i_ctr  (r_ctr[w_upd_idx]),
    .i_inc  (upd_taken),
    .o_next (w_ctr_next)
  );

  always_ff @(posedge CLK) begin
    if (w_restart) begin
      r_state <= BP_INIT;
      r_ptr   <= '0;
      r_ghr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        BP_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == '1) begin
            r_state <= BP_RUN;
            r_ready <= 1'b1;
          end
        end
        BP_RUN: begin
          if (upd_valid) r_ghr <= GHR_RW'({r_ghr, upd_taken});
        end
        default: r_state <= BP_INIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!w_restart) begin
      if (r_state == BP_INIT) r_ctr[r_ptr] <= CTR_INIT;
      else if (w_upd_en)      r_ctr[w_upd_idx] <= w_ctr_next;
    end
  end

  assign ready        = r_ready;
  assign lookup_taken = r_ready & r_ctr[w_lk_idx][CTR_W-1];

`ifdef BRANCH_PRED_BTB_EN
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] target;
  } btb_entry_t;

  btb_entry_t r_btb [ENTRIES];
  btb_entry_t w_lk_ent;
  logic       w_hit;
  logic       w_unused;

  always_ff @(posedge CLK) begin
    if (!w_restart) begin
      if (r_state == BP_INIT) begin
        r_btb[r_ptr].valid <= 1'b0;
      end else if (w_upd_en && upd_taken) begin
        r_btb[upd_pc[IDX_W+1:2]] <= '{valid: 1'b1,
                                      tag: upd_pc[WORD_W-1:IDX_W+2],
                                      target: upd_target};
      end
    end
  end

  assign w_lk_ent      = r_btb[lookup_pc[IDX_W+1:2]];
  assign w_hit         = r_ready & w_lk_ent.valid & (w_lk_ent.tag == lookup_pc[WORD_W-1:IDX_W+2]);
  assign lookup_hit    = w_hit;
  assign lookup_target = w_hit ? w_lk_ent.target : '0;
  assign w_unused      = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  logic w_unused;

  assign lookup_hit    = 1'b0;
  assign lookup_target = '0;
  assign w_unused      = ^{lookup_pc[WORD_W-1:IDX_W+2], lookup_pc[1:0],
                           upd_pc[WORD_W-1:IDX_W+2], upd_pc[1:0], upd_target};
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed scoreboard bench: instance A is PC-indexed (GHR_W=0), instance B is gshare (GHR_W=2).
module tb_branch_predictor_table;
  import branch_predictor_table_pkg::*;

`ifdef BRANCH_PRED_BTB_EN
  localparam logic BTB = 1'b1;
`else
  localparam logic BTB = 1'b0;
`endif

  localparam int S_RDY_A = 0, S_TK_A = 1, S_HIT_A = 2, S_TGT_A = 3, S_RDY_B = 4, S_TK_B = 5;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RST;
  logic              flush_a, ready_a, ltk_a, lhit_a, uv_a, ut_a;
  logic [WORD_W-1:0] lpc_a, ltgt_a, upc_a, utgt_a;
  logic              flush_b, ready_b, ltk_b, lhit_b, uv_b, ut_b;
  logic [WORD_W-1:0] lpc_b, ltgt_b, upc_b, utgt_b;

  branch_predictor_table #(.ENTRIES(64), .CTR_W(2), .GHR_W(0)) dut_a (
    .CLK(CLK), .RST(RST), .flush(flush_a), .ready(ready_a),
    .lookup_pc(lpc_a), .lookup_taken(ltk_a), .lookup_hit(lhit_a), .lookup_target(ltgt_a),
    .upd_valid(uv_a), .upd_pc(upc_a), .upd_taken(ut_a), .upd_target(utgt_a)
  );

  branch_predictor_table #(.ENTRIES(64), .CTR_W(2), .GHR_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .flush(flush_b), .ready(ready_b),
    .lookup_pc(lpc_b), .lookup_taken(ltk_b), .lookup_hit(lhit_b), .lookup_target(ltgt_b),
    .upd_valid(uv_b), .upd_pc(upc_b), .upd_taken(ut_b), .upd_target(utgt_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_RDY_A: return 32'(ready_a);
      S_TK_A:  return 32'(ltk_a);
      S_HIT_A: return 32'(lhit_a);
      S_TGT_A: return ltgt_a;
      S_RDY_B: return 32'(ready_b);
      S_TK_B:  return 32'(ltk_b);
      default: return '1;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic chk_val(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty: observed %0h, no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input int sel);
    #1;
    chk_val(pick(sel));
  endtask

  task automatic ex(input string tag, input int sel, input logic [31:0] val);
    push(tag, val);
    chk(sel);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd_a(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    uv_a = 1'b1; upc_a = pc; ut_a = taken; utgt_a = tgt;
    cyc();
    uv_a = 1'b0;
  endtask

  task automatic upd_b(input logic [31:0] pc, input logic taken);
    uv_b = 1'b1; upc_b = pc; ut_b = taken; utgt_b = '0;
    cyc();
    uv_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic any_tk;

    RST = 1'b1;
    flush_a = 1'b0; uv_a = 1'b0; ut_a = 1'b0; upc_a = '0; utgt_a = '0; lpc_a = 32'h100;
    flush_b = 1'b0; uv_b = 1'b0; ut_b = 1'b0; upc_b = '0; utgt_b = '0; lpc_b = 32'h0;
    cyc();
    ex("reset_ready",  S_RDY_A, 0);
    ex("reset_taken",  S_TK_A,  0);
    ex("reset_hit",    S_HIT_A, 0);
    ex("reset_target", S_TGT_A, 0);

    // Initialisation length after reset release
    RST = 1'b0;
    n = 0; any_tk = 1'b0;
    push("init_cycles", 64);
    do begin
      cyc();
      n++;
      any_tk |= ltk_a;
      lpc_a = 32'(n * 4);
    end while (!ready_a && n < 200);
    chk_val(32'(n));
    push("init_taken_low", 0);
    chk_val(32'(any_tk));
    ex("ready_b_after_init", S_RDY_B, 1);

    // Training a counter at pc 0x100 up to saturation and back down
    lpc_a = 32'h100;
    ex("wnt_initial", S_TK_A, 0);
    push("train_t1", 1); upd_a(32'h100, 1'b1, '0); chk(S_TK_A);
    push("train_t2", 1); upd_a(32'h100, 1'b1, '0); chk(S_TK_A);
    push("train_t3", 1); upd_a(32'h100, 1'b1, '0); chk(S_TK_A);
    push("train_t4", 1); upd_a(32'h100, 1'b1, '0); chk(S_TK_A);
    push("sat3_nt1", 1); upd_a(32'h100, 1'b0, '0); chk(S_TK_A);
    push("sat3_nt2", 0); upd_a(32'h100, 1'b0, '0); chk(S_TK_A);

    // Same-cycle lookup and update: no bypass
    lpc_a = 32'h40;
    uv_a = 1'b1; upc_a = 32'h40; ut_a = 1'b1;
    ex("same_cycle_pre", S_TK_A, 0);
    cyc();
    uv_a = 1'b0;
    ex("same_cycle_post", S_TK_A, 1);

    // Floor saturation at zero
    lpc_a = 32'h80;
    upd_a(32'h80, 1'b0, '0);
    upd_a(32'h80, 1'b0, '0);
    push("sat0_then_t", 0); upd_a(32'h80, 1'b1, '0); chk(S_TK_A);

    // Target buffer: taken update then same-index different-tag lookup
    upd_a(32'h200, 1'b1, 32'h400);
    lpc_a = 32'h200;
    ex("btb_hit",    S_HIT_A, 32'(BTB));
    ex("btb_target", S_TGT_A, BTB ? 32'h400 : 32'h0);
    lpc_a = 32'h200 + 64 * 4;
    ex("btb_alias_hit",    S_HIT_A, 0);
    ex("btb_alias_target", S_TGT_A, 0);

    // Flush mid-init restarts the pointer; updates during init are ignored
    lpc_a = 32'h100;
    upd_a(32'h100, 1'b1, '0);
    push("pre_flush_t", 1); upd_a(32'h100, 1'b1, '0); chk(S_TK_A);
    flush_a = 1'b1; cyc(); flush_a = 1'b0;
    ex("flush_ready_low", S_RDY_A, 0);
    ex("flush_taken_low", S_TK_A,  0);
    repeat (20) cyc();
    flush_a = 1'b1; cyc(); flush_a = 1'b0;
    n = 0;
    push("reflush_cycles", 64);
    do begin
      cyc();
      n++;
      if (!ready_a && n >= 55) begin
        uv_a = 1'b1; upc_a = 32'h100; ut_a = 1'b1;
      end
    end while (!ready_a && n < 200);
    uv_a = 1'b0;
    chk_val(32'(n));
    ex("post_flush_wnt", S_TK_A, 0);
    push("post_flush_t", 1); upd_a(32'h100, 1'b1, '0); chk(S_TK_A);
    lpc_a = 32'h200;
    ex("btb_cleared", S_HIT_A, 0);

    // gshare: history 11 folds pc 0xC onto entry 0
    lpc_b = 32'hC;
    ex("gs_pre", S_TK_B, 0);
    upd_b(32'h0, 1'b1);
    upd_b(32'h0, 1'b1);
    lpc_b = 32'hC;
    ex("gs_c_to_0", S_TK_B, 1);
    lpc_b = 32'h0;
    ex("gs_0_to_3", S_TK_B, 0);
    upd_b(32'hC, 1'b0);
    lpc_b = 32'hC;
    ex("gs_c_to_1", S_TK_B, 1);
    lpc_b = 32'h8;
    ex("gs_8_to_0", S_TK_B, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
